// File: rtl/seq_pkg.sv
// Shared types and helpers for the programmable sequence counter.
// Holds the state encoding, index/length width helpers and the length clamp.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } seq_state_e;

  // Index width needed to address depth entries.
  function automatic int seq_iw(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  // Width needed to hold a length of 0..depth.
  function automatic int seq_lw(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int SEQ_DEPTH = 4;
  localparam int SEQ_IW    = seq_iw(SEQ_DEPTH);
  localparam int SEQ_LW    = seq_lw(SEQ_DEPTH);

  // A zero or over-range length means "use the whole table".
  function automatic int unsigned seq_clamp_len(input int unsigned len,
                                                input int unsigned depth);
    if ((len == 32'd0) || (len > depth)) begin
      return depth;
    end else begin
      return len;
    end
  endfunction

endpackage

// File: rtl/seq_table.sv
// DEPTH x WIDTH code table: synchronous reset to a default pattern,
// one write port, one combinational read port.
module seq_table
  import seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter logic [WIDTH*DEPTH-1:0] DEFAULT_SEQ = {3'd7, 3'd3, 3'd2, 3'd0},
  localparam int IW = seq_iw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Table storage; reset reloads the default pattern and beats any write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= DEFAULT_SEQ[i*WIDTH +: WIDTH];
      end
    end else if (we && (32'(waddr) < 32'(DEPTH))) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Combinational read of the registered contents.
  always_comb begin
    rdata = mem_r[raddr];
  end

endmodule

// File: rtl/seq_pattern_counter.sv
// Sequence counter stepping through a programmable code table, forward or
// reverse, in wrap or one-shot mode, with a runtime sequence length.
module seq_pattern_counter
  import seq_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4,
  parameter logic [WIDTH*DEPTH-1:0] DEFAULT_SEQ = {3'd7, 3'd3, 3'd2, 3'd0},
  localparam int IW = seq_iw(DEPTH),
  localparam int LW = seq_lw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic [LW-1:0]    cfg_len,
  input  logic             cfg_we,
  input  logic [IW-1:0]    cfg_addr,
  input  logic [WIDTH-1:0] cfg_data,
  output logic [WIDTH-1:0] count,
  output logic [IW-1:0]    idx,
  output logic             busy,
  output logic             wrap,
  output logic             done
);

  seq_state_e    state_r, state_n;
  logic [IW-1:0] idx_r, idx_n;
  logic [LW-1:0] len_r, len_n;
  logic          dir_r, dir_n;
  logic          mode_r, mode_n;
  logic          busy_r, busy_n;
  logic          wrap_r, wrap_n;
  logic          done_r, done_n;

  logic [LW-1:0] start_len_s;
  logic [IW-1:0] start_first_s;
  logic [IW-1:0] first_s;
  logic [IW-1:0] last_s;
  logic          at_last_step_s;

  seq_table #(
    .WIDTH       (WIDTH),
    .DEPTH       (DEPTH),
    .DEFAULT_SEQ (DEFAULT_SEQ)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_r),
    .rdata (count)
  );

  // First/last indices for the latched config and for a config about to be latched.
  always_comb begin
    start_len_s   = LW'(seq_clamp_len(32'(cfg_len), DEPTH));
    start_first_s = dir   ? IW'(start_len_s - LW'(1)) : {IW{1'b0}};
    first_s       = dir_r ? IW'(len_r - LW'(1))       : {IW{1'b0}};
    last_s        = dir_r ? {IW{1'b0}}                : IW'(len_r - LW'(1));
  end

  // State and configuration registers; pulses and busy are registered too.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      idx_r   <= {IW{1'b0}};
      len_r   <= LW'(DEPTH);
      dir_r   <= 1'b0;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      wrap_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      len_r   <= len_n;
      dir_r   <= dir_n;
      mode_r  <= mode_n;
      busy_r  <= busy_n;
      wrap_r  <= wrap_n;
      done_r  <= done_n;
    end
  end

  // Next-state and index logic; priority is stop > start > en.
  always_comb begin
    state_n = state_r;
    idx_n   = idx_r;
    len_n   = len_r;
    dir_n   = dir_r;
    mode_n  = mode_r;
    if (stop) begin
      state_n = ST_IDLE;
    end else if (start) begin
      len_n   = start_len_s;
      dir_n   = dir;
      mode_n  = mode;
      idx_n   = start_first_s;
      state_n = ST_RUN;
    end else begin
      case (state_r)
        ST_IDLE: state_n = ST_IDLE;
        ST_RUN: begin
          if (!en) begin
            state_n = ST_RUN;
          end else if (idx_r != last_s) begin
            idx_n = dir_r ? (idx_r - IW'(1)) : (idx_r + IW'(1));
          end else if (!mode_r) begin
            idx_n = first_s;
          end else begin
            state_n = ST_DONE;
          end
        end
        ST_DONE: state_n = ST_DONE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Output decode: wrap/done fire only on an enabled step at the last index.
  always_comb begin
    at_last_step_s = (state_r == ST_RUN) && en && !stop && !start && (idx_r == last_s);
    wrap_n         = at_last_step_s && !mode_r;
    done_n         = at_last_step_s && mode_r;
    busy_n         = (state_n == ST_RUN);
  end

  assign idx  = idx_r;
  assign busy = busy_r;
  assign wrap = wrap_r;
  assign done = done_r;

endmodule
